// File: rtl/fifo_ctrl.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// registered read data with valid strobe and sticky error flags. FIFO_HWM_EN adds a high-water mark.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_HWM_EN
  ,
  input  logic                  clr_hwm,
  output logic [AW:0]           hwm
`endif
);

  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count_next;
  logic                  wr_acc;
  logic                  rd_acc;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  assign wr_acc = we & ~full;
  assign rd_acc = re & ~empty;

  always_comb begin
    count_next = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      count <= count_next;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + 1'b1;
        data_out   <= mem[rd_ptr];
        data_valid <= 1'b1;
      end else begin
        data_valid <= 1'b0;
      end
      // A new error outranks a clear in the same cycle.
      if (we && full)      overflow  <= 1'b1;
      else if (clr_err)    overflow  <= 1'b0;
      if (re && empty)     underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

`ifdef FIFO_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   hwm <= '0;
    else if (clr_hwm)             hwm <= count_next;
    else if (count_next > hwm)    hwm <= count_next;
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl at depth 4 (AF=3, AE=1);
// high-water-mark checks run when FIFO_HWM_EN is defined.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we, re, clr_err;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid, empty, full, almost_empty, almost_full;
  logic [2:0] count;
  logic       overflow, underflow;
`ifdef FIFO_HWM_EN
  logic       clr_hwm;
  logic [2:0] hwm;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4),
    .AF_LEVEL  (3),
    .AE_LEVEL  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .re          (re),
    .data_in     (data_in),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef FIFO_HWM_EN
    ,
    .clr_hwm     (clr_hwm),
    .hwm         (hwm)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    we = w; re = r; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; clr_err = 1'b0; data_in = '0;
`ifdef FIFO_HWM_EN
    clr_hwm = 1'b0;
`endif
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_errs", 32'({overflow, underflow}), 32'd0);
    rst_n = 1'b1;

    // 1. fill
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'hA1 + 8'(i));
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_ae", 32'(almost_empty), (i == 0) ? 32'd1 : 32'd0);
      check("fill_af", 32'(almost_full), (i >= 2) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 3) ? 32'd1 : 32'd0);
    end

    // 2. overflow then drain
    cyc(1'b1, 1'b0, 8'h55);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check("drain_data", 32'(data_out), 32'(8'hA1 + 8'(i)));
      check("drain_valid", 32'(data_valid), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b0, 8'h00);
    check("idle_valid", 32'(data_valid), 32'd0);
    check("idle_hold", 32'(data_out), 32'hA4);

    // 3. underflow and error clearing
    cyc(1'b0, 1'b1, 8'h00);
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_valid", 32'(data_valid), 32'd0);
    check("udf_hold", 32'(data_out), 32'hA4);
    clr_err = 1'b1;
    cyc(1'b0, 1'b1, 8'h00);
    check("clr_vs_new_udf", 32'(underflow), 32'd1);
    check("clr_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    clr_err = 1'b0;
    check("clr_errs", 32'({overflow, underflow}), 32'd0);

    // 4. simultaneous traffic across pointer wraps
    cyc(1'b1, 1'b0, 8'h10);
    cyc(1'b1, 1'b0, 8'h11);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 8'h12 + 8'(k));
      check("sim_count", 32'(count), 32'd2);
      check("sim_data", 32'(data_out), 32'(8'h10 + 8'(k)));
      check("sim_valid", 32'(data_valid), 32'd1);
    end
    cyc(1'b1, 1'b0, 8'h1C);
    cyc(1'b1, 1'b0, 8'h1D);
    check("refill_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 8'h77);
    check("full_rw_count", 32'(count), 32'd3);
    check("full_rw_ovf", 32'(overflow), 32'd1);
    check("full_rw_data", 32'(data_out), 32'h1A);

    // 5. asynchronous reset between edges
    we = 1'b0; re = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_dout", 32'(data_out), 32'd0);
    check("arst_valid", 32'(data_valid), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    #1 rst_n = 1'b1;

`ifdef FIFO_HWM_EN
    // 6. high-water mark
    check("hwm_rst", 32'(hwm), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);
    check("hwm_peak", 32'(hwm), 32'd3);
    check("hwm_drained", 32'(count), 32'd0);
    clr_hwm = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    clr_hwm = 1'b0;
    check("hwm_clr", 32'(hwm), 32'd0);
    cyc(1'b1, 1'b0, 8'h42);
    check("hwm_one", 32'(hwm), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Parametrised synchronous FIFO. Successor to the lab FIFO block.
- Adds true full at DEPTH entries, free-running power-of-two pointer wrap, and an occupancy count.
- Adds programmable almost-full/almost-empty flags, registered read data with a valid strobe, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- FIFO_DEPTH, 16, number of entries; must be a power of two, ≥2. Derived AW = $clog2(FIFO_DEPTH).
- AF_LEVEL, FIFO_DEPTH-1, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- re  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- clr_err  in  1  clears overflow and underflow.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  one-cycle strobe: data_out was updated on this edge.
- empty  out  1  count == 0.
- full  out  1  count == FIFO_DEPTH.
- almost_empty  out  1  count ≤ AE_LEVEL.
- almost_full  out  1  count ≥ AF_LEVEL.
- count  out  AW+1  current occupancy, range 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset: asynchronous, active-low; one clock; rst_n asserted low clears state immediately, with no clock edge required.
  - wr_ptr, rd_ptr, count, data_out, data_valid, overflow and underflow reset to 0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL ≥ 1).
  - Memory array is not reset.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = we & ~full.
  - rd_acc = re & ~empty.
- Write: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1. Pointers are AW bits and wrap modulo FIFO_DEPTH with no compare logic.
- Read: on rd_acc, data_out <= mem[rd_ptr], rd_ptr <= rd_ptr+1, and data_valid <= 1.
  - Otherwise data_valid <= 0 and data_out holds its value.
  - Read latency: 1 clock from the re edge.
- Count update:
  - +1 when wr_acc & ~rd_acc.
  - −1 when rd_acc & ~wr_acc.
  - Unchanged otherwise, including when both are accepted.
- Flags are combinational from the count register only.
- Simultaneous events:
  - Full with we&re: read accepted, write rejected; overflow set; count goes FIFO_DEPTH → FIFO_DEPTH−1.
  - Empty with we&re: write accepted, read rejected; underflow set; count goes 0 → 1.
  - Otherwise, with both requests and 0 < count < FIFO_DEPTH, both are accepted and count is unchanged.
  - A same-address read/write conflict cannot occur. Equal pointers imply the FIFO is full or empty, and one side is then rejected.
- Errors:
  - overflow <= 1 on we & full; underflow <= 1 on re & empty.
  - Both hold until clr_err or reset.
  - If clr_err is high in the same cycle as a new error, the error wins and the flag stays 1.
- Rejected operations change no pointer, count or memory entry.

Optional Feature:
Macro FIFO_HWM_EN.
- Defined: adds input clr_hwm (1 bit) and output hwm (AW+1 bits), a high-water mark.
  - Resets to 0.
  - Each edge: hwm <= max(hwm, count_next), where count_next is the value count takes on that edge.
  - On clr_hwm: hwm <= count_next.
- Undefined: neither port exists and there is no related logic.

Test Plan:
All scenarios use DATA_WIDTH=8, FIFO_DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
1. Fill after reset: write 0xA1..0xA4 on 4 consecutive edges.
   - count 1,2,3,4.
   - almost_empty drops after the 2nd write; almost_full rises after the 3rd; full=1 after the 4th.
2. Overflow then drain:
   - Write 0x55 while full → overflow=1, count=4, contents unchanged.
   - Then 4 reads → data_out A1,A2,A3,A4, each valid one edge after re with data_valid pulsing.
   - empty=1 after the 4th read; 0x55 never appears.
3. Underflow: re while empty → underflow=1, data_valid=0, data_out holds 0xA4. Then clr_err → both error flags 0 next edge.
4. Simultaneous and wrap:
   - At count=2, hold we&re for 10 cycles with incrementing data → count stays 2; output is strictly FIFO order across ≥2 pointer wraps.
   - At full, we&re → count=3, overflow=1.
5. Async reset: at count=3, pulse rst_n low between clock edges → count=0, empty=1, data_out=0 and flags cleared immediately, without waiting for a clock edge.
6. FIFO_HWM_EN defined:
   - Fill to 3, drain to 0 → hwm=3.
   - clr_hwm at count=0 → hwm=0.
   - One write → hwm=1.
